// File: rtl/seq_pkg.sv
// Shared definitions for the 100-sync frame transmitter and its matching detector.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } seq_tx_state_t;

   localparam int                    SEQ_SYNC_W   = 3;
   localparam logic [SEQ_SYNC_W-1:0] SEQ_SYNC_PAT = 3'b100;

   // Largest of three sizes, used to pick a counter width wide enough for any phase
   function automatic int seq_max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return m;
   endfunction

endpackage

// File: rtl/seq_bit_counter.sv
// Loadable down-counter that flags the final cycle of a transmitter phase.
// Latency: load/decrement take effect on the next rising edge; last is combinational.
// Backpressure: none; stops at 1 and never wraps, waiting for the next load.
module seq_bit_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         last
);

   // Load has priority; decrement saturates at 1 so an idle counter stays put
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count > W'(1))) begin
         count <= count - W'(1);
      end
   end

   assign last = (count == W'(1));

endmodule

// File: rtl/seq_frame_tx.sv
// Serializes an accepted payload MSB-first behind a sync pattern, then holds a forced-zero gap.
// Latency: first sync bit on out in the cycle after the accepting edge; SYNC_W+DATA_W+GAP_CYCLES busy cycles.
// Backpressure: data_ready high only in IDLE; data_valid outside IDLE is ignored, nothing queues.
module seq_frame_tx
   import seq_pkg::*;
#(
   parameter int                DATA_W     = 8,
   parameter int                SYNC_W     = SEQ_SYNC_W,
   parameter logic [SYNC_W-1:0] SYNC_PAT   = SEQ_SYNC_PAT,
   parameter int                GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              data_ready,
   output logic              out,
   output logic              out_en,
   output logic              frame_done
);

   localparam int CNT_W = $clog2(seq_max3(SYNC_W, DATA_W, GAP_CYCLES) + 1);

   seq_tx_state_t     state, state_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              out_n, out_en_n, done_n;
   logic              cnt_load, cnt_dec, cnt_last;
   logic [CNT_W-1:0]  cnt_val, cnt;
   logic [SYNC_W-1:0] sync_bits;

   seq_bit_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt),
      .last     (cnt_last)
   );

   // While count k is on the line (sync bit k-1), bit k-2 is the next one to register
   assign sync_bits  = SYNC_PAT >> (cnt - CNT_W'(2));
   assign data_ready = (state == IDLE);

   // Next-state and next-output decode; outputs are computed one cycle early and registered
   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      cnt_load = 1'b0;
      cnt_val  = '0;
      cnt_dec  = 1'b0;
      out_n    = 1'b0;
      out_en_n = 1'b0;
      done_n   = 1'b0;
      case (state)
         IDLE: begin
            if (data_valid) begin
               state_n  = SYNC;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(SYNC_W);
               shreg_n  = data_in;
               out_n    = SYNC_PAT[SYNC_W-1];
               out_en_n = 1'b1;
            end
         end
         SYNC: begin
            out_en_n = 1'b1;
            if (cnt_last) begin
               state_n  = DATA;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(DATA_W);
               out_n    = shreg[DATA_W-1];
               shreg_n  = shreg << 1;
               done_n   = (DATA_W == 1);
            end else begin
               cnt_dec = 1'b1;
               out_n   = sync_bits[0];
            end
         end
         DATA: begin
            if (cnt_last) begin
               if (GAP_CYCLES == 0) begin
                  state_n = IDLE;
               end else begin
                  state_n  = GAP;
                  cnt_load = 1'b1;
                  cnt_val  = CNT_W'(GAP_CYCLES);
               end
            end else begin
               cnt_dec  = 1'b1;
               out_n    = shreg[DATA_W-1];
               out_en_n = 1'b1;
               shreg_n  = shreg << 1;
               done_n   = (cnt == CNT_W'(2));
            end
         end
         GAP: begin
            if (cnt_last) begin
               state_n = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register; reset aborts any frame in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Shift register and glitch-free output registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shreg      <= '0;
         out        <= 1'b0;
         out_en     <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         shreg      <= shreg_n;
         out        <= out_n;
         out_en     <= out_en_n;
         frame_done <= done_n;
      end
   end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

- Serial frame transmitter: the other end of the `100` sequence detector.
- Accepts a parallel payload word through a valid/ready handshake.
- Serializes it MSB-first as one bit per clock, preceded by the sync pattern `100` and followed by a programmable idle gap.
- Sits upstream of the detector, so the detector sees the sync pattern immediately before each payload.

## Interface

Parameters:
- DATA_W, 8, payload width in bits (≥1)
- SYNC_W, 3, sync pattern width (≥1)
- SYNC_PAT, 3'b100, sync pattern, sent MSB-first
- GAP_CYCLES, 2, forced-zero idle cycles after each frame (≥0)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset; low clears all state immediately
- data_in  input  DATA_W  payload word
- data_valid  input  1  payload offered
- data_ready  output  1  block can accept; high only in IDLE
- out  output  1  serial bit stream (registered)
- out_en  output  1  high while a sync or payload bit is on `out` (registered)
- frame_done  output  1  one-cycle pulse coincident with the last payload bit

## Operation

- FSM states: IDLE, SYNC, DATA, GAP.
- **IDLE:**
  - data_ready=1, out=0, out_en=0.
  - On a rising edge with data_valid=1, latch data_in into the shift register, load the bit counter, and go to SYNC.
  - data_valid=0 holds IDLE.
- **SYNC:**
  - Drive SYNC_PAT[SYNC_W-1] down to SYNC_PAT[0], one bit per cycle, with out_en=1.
  - After SYNC_W cycles, go to DATA.
- **DATA:**
  - Drive the latched word MSB-first, one bit per cycle, with out_en=1.
  - On the cycle carrying bit 0, frame_done=1.
  - After DATA_W cycles, go to GAP, or to IDLE if GAP_CYCLES=0.
- **GAP:**
  - out=0, out_en=0, data_ready=0 for GAP_CYCLES cycles, then IDLE.
- data_in is sampled only at acceptance. Later changes to data_in do not affect the frame in flight.
- data_valid outside IDLE is ignored; nothing is queued.
- The bit counter width is $clog2(max(SYNC_W, DATA_W, GAP_CYCLES)+1). It counts down to 1 and is reloaded at each state entry. It never wraps.

## Timing

- Reset values (reset low, asynchronous): state=IDLE, out=0, out_en=0, frame_done=0, data_ready=1, shift register=0, counter=0.
- Reset asserted mid-frame aborts the frame at once. `out` drops to 0 without waiting for a clock edge. No frame_done is issued.
- Handshake: transfer occurs on the rising edge where data_valid && data_ready. data_ready is a combinational decode of state==IDLE.
- Latency: the first sync bit appears on `out` in the cycle after the accepting edge.
- Frame occupancy: SYNC_W+DATA_W cycles with out_en=1, then GAP_CYCLES cycles of gap, then at least one IDLE cycle before the next acceptance.
- Minimum acceptance-to-acceptance spacing: SYNC_W+DATA_W+GAP_CYCLES+1 cycles. This is 14 cycles at the defaults.
- frame_done is high for exactly one cycle per completed frame. It aligns with the last payload bit, not with the gap.
- Outputs are glitch-free registers, except data_ready.

## Structure

- The shared package `seq_pkg` holds:
  - the state enum `seq_tx_state_t` {IDLE, SYNC, DATA, GAP};
  - the default sync constant `SEQ_SYNC_PAT = 3'b100` with `SEQ_SYNC_W = 3`.
- The detector and this block both import it, so the pattern stays consistent across the two ends.
- One sub-module is natural: `seq_bit_counter`, a loadable down-counter with a `last` flag. The FSM reloads it at each state entry.
- Everything else (FSM, shift register, output registers) lives in `seq_frame_tx`.

## Test plan

- **Reset/idle:** hold reset low for 2 cycles, then release with data_valid=0 for 5 cycles.
  - Required: out=0, out_en=0, frame_done=0, data_ready=1 throughout.
- **Single frame at defaults:** present data_in=8'hA5 with data_valid=1 for one edge.
  - Required on `out`: 1,0,0 then 1,0,1,0,0,1,0,1 with out_en=1 for 11 cycles.
  - Required: frame_done only on the 11th cycle, then 2 gap cycles of out=0 and data_ready=0, then data_ready=1.
- **Loopback:** connect out to the `100` detector and send 8'h00.
  - Required: the detector flags the sync, with the detection cycle 3 cycles after the first sync bit.
  - Required: the payload zeros then complete the frame.
- **Back-to-back:** hold data_valid=1 continuously with data_in=8'hFF then 8'h3C.
  - Required: second acceptance exactly 14 cycles after the first.
  - Required: the second frame's sync starts on the next cycle.
  - Required: data_in changes during frame 1 do not corrupt it.
- **Ignored valid:** pulse data_valid with 8'h12 during DATA of a frame carrying 8'h81.
  - Required: the frame completes as 8'h81 and 8'h12 is never transmitted.
- **Reset mid-frame:** drive reset low asynchronously (between edges) during payload bit 4 of 8'hF0.
  - Required: out and out_en fall to 0 before the next edge, no frame_done, state returns to IDLE.
  - Required: after release, a fresh frame with 8'h0F transmits correctly.
